ds1302_rtc_ctrl: RTL

DS1302_RTC_CTRL -- requirements
Module: ds1302_rtc_ctrl

---
 rtl/ds1302_rtc_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ds1302_rtc_ctrl.sv
// DS1302 RTC sequencer: periodic 7-byte read sweep, write-protected time set.
// Optional macro DS1302_RTC_INIT_EN: load a fixed time once after reset release.
module ds1302_rtc_ctrl #(
  parameter logic [23:0] POLL_DIV = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        set_ack,
  output logic [55:0] rtc_time,
  output logic        time_valid,
  output logic        busy,
  output logic        cmd_read,
  output logic        cmd_write,
  input  logic        cmd_read_ack,
  input  logic        cmd_write_ack,
  output logic [7:0]  read_addr,
  output logic [7:0]  write_addr,
  output logic [7:0]  write_data,
  input  logic [7:0]  read_data
);

  // state    | meaning
  // S_IDLE   | counting poll interval, waiting for a set request
  // S_WP_OFF | clearing write-protect (0x8E <- 0x00)
  // S_WRITE  | writing time byte idx (sec..year)
  // S_WP_ON  | restoring write-protect (0x8E <- 0x80)
  // S_READ   | reading time byte idx into shadow
  // S_DONE   | write sequence finished, pulse set_ack
  typedef enum logic [2:0] {S_IDLE, S_WP_OFF, S_WRITE, S_WP_ON, S_READ, S_DONE} state_t;

  localparam logic [55:0] INIT_TIME = 56'h19_03_06_12_00_00_00;
`ifdef DS1302_RTC_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  state_t      state;
  logic [2:0]  idx;
  logic [23:0] poll_cnt;
  logic        pend;
  logic [55:0] pend_time;
  logic [55:0] wr_time;
  logic [47:0] shadow;
  logic        init_pend;
  logic        init_run;

  assign busy = (state != S_IDLE);

  // CH (sec bit7) and 12/24 (hour bit7) are always written as 0
  function automatic logic [7:0] wr_byte(input logic [55:0] t, input logic [2:0] i);
    logic [7:0] b;
    b = t[{i, 3'b000} +: 8];
    if (i == 3'd0 || i == 3'd2) b[7] = 1'b0;
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      poll_cnt   <= 24'd0;
      pend       <= 1'b0;
      pend_time  <= 56'd0;
      wr_time    <= 56'd0;
      shadow     <= 48'd0;
      init_pend  <= INIT_EN;
      init_run   <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      set_ack    <= 1'b0;
      time_valid <= 1'b0;
      rtc_time   <= 56'd0;
      read_addr  <= 8'h00;
      write_addr <= 8'h00;
      write_data <= 8'h00;
    end else begin
      set_ack    <= 1'b0;
      time_valid <= 1'b0;
      if (set_req && (state != S_IDLE || init_pend)) begin
        pend      <= 1'b1;
        pend_time <= set_time;
      end
      if (state != S_IDLE) poll_cnt <= 24'd0;
      case (state)
        S_IDLE: begin
          if (init_pend) begin
            init_pend <= 1'b0;
            init_run  <= 1'b1;
            wr_time   <= INIT_TIME;
            poll_cnt  <= 24'd0;
            state     <= S_WP_OFF;
          end else if (set_req || pend) begin
            wr_time  <= set_req ? set_time : pend_time;
            pend     <= 1'b0;
            init_run <= 1'b0;
            poll_cnt <= 24'd0;
            state    <= S_WP_OFF;
          end else if (poll_cnt == POLL_DIV - 24'd1) begin
            poll_cnt <= 24'd0;
            idx      <= 3'd0;
            state    <= S_READ;
          end else begin
            poll_cnt <= poll_cnt + 24'd1;
          end
        end
        S_WP_OFF: begin
          if (!cmd_write) begin
            cmd_write  <= 1'b1;
            write_addr <= 8'h8E;
            write_data <= 8'h00;
          end else if (cmd_write_ack) begin
            cmd_write <= 1'b0;
            idx       <= 3'd0;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!cmd_write) begin
            cmd_write  <= 1'b1;
            write_addr <= 8'h80 + {4'b0000, idx, 1'b0};
            write_data <= wr_byte(wr_time, idx);
          end else if (cmd_write_ack) begin
            cmd_write <= 1'b0;
            if (idx == 3'd6) state <= S_WP_ON;
            else idx <= idx + 3'd1;
          end
        end
        S_WP_ON: begin
          if (!cmd_write) begin
            cmd_write  <= 1'b1;
            write_addr <= 8'h8E;
            write_data <= 8'h80;
          end else if (cmd_write_ack) begin
            cmd_write <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          set_ack  <= ~init_run;
          init_run <= 1'b0;
          idx      <= 3'd0;
          state    <= S_IDLE;
        end
        S_READ: begin
          if (!cmd_read) begin
            cmd_read  <= 1'b1;
            read_addr <= 8'h81 + {4'b0000, idx, 1'b0};
          end else if (cmd_read_ack) begin
            cmd_read <= 1'b0;
            if (idx == 3'd6) begin
              // shadow holds day..sec (sec lowest); year arrives now
              rtc_time   <= {read_data, shadow[47:24], 1'b0, shadow[22:8], 1'b0, shadow[6:0]};
              time_valid <= 1'b1;
              idx        <= 3'd0;
              state      <= S_IDLE;
            end else begin
              shadow <= {read_data, shadow[47:8]};
              idx    <= idx + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
